// File: rtl/load_unit.sv
// RISC-V load unit: issues one word-aligned memory read per load, extracts and
// sign/zero-extends the addressed byte/halfword, and hands the result to writeback.
module load_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  input  logic        ld_ready,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        ld_err
);

  // Handshakes: mem_req holds with a stable mem_addr until the cycle mem_gnt is
  // high; ld_valid holds with stable ld_data/ld_rd/ld_err until the cycle
  // ld_ready is high. mem_rvalid is only honoured while waiting for data.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_func3;
  logic [31:0]       r_addr;
  logic [4:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_data;
  logic              r_err;

  logic              w_accept;
  logic              w_legal;
  logic              w_misal;
  logic              w_ok;
  logic              w_timeout;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  assign w_accept  = (r_state == S_IDLE) && start && (op == OP_LOAD);
  assign w_legal   = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                     (func3 == 3'b100) || (func3 == 3'b101);
  assign w_misal   = (((func3 == 3'b001) || (func3 == 3'b101)) && addr[0]) ||
                     ((func3 == 3'b010) && (addr[1:0] != 2'b00));
  assign w_ok      = w_legal && !w_misal;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign w_off  = r_addr[1:0];
  assign w_byte = mem_rdata[{w_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = mem_rdata;
    case (r_func3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'b0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'b0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_ok ? S_REQ : S_DONE;
      S_REQ:  if (mem_gnt) w_next = S_WAIT;
      S_WAIT: if (mem_rvalid || w_timeout) w_next = S_DONE;
      S_DONE: if (ld_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = 1'b0;
    mem_req  = 1'b0;
    ld_valid = 1'b0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_REQ:  begin busy = 1'b1; mem_req = 1'b1; end
      S_WAIT: busy = 1'b1;
      S_DONE: begin busy = 1'b1; ld_valid = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Request fields, wait counter and the result held for writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      r_func3 <= 3'b0;
      r_addr  <= 32'b0;
      r_rd    <= 5'b0;
      r_cnt   <= '0;
      r_data  <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_func3 <= func3;
        r_addr  <= addr;
        r_rd    <= rd_in;
        if (!w_ok) begin
          r_data <= 32'b0;
          r_err  <= 1'b1;
        end
      end
      if ((r_state == S_REQ) && mem_gnt) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem_rvalid) begin
          r_data <= w_ext;
          r_err  <= 1'b0;
        end else if (w_timeout) begin
          r_data <= 32'b0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  assign mem_addr = {r_addr[31:2], 2'b00};
  assign ld_data  = r_data;
  assign ld_rd    = r_rd;
  assign ld_err   = r_err;

endmodule
